// File: rtl/tnn_popcount_acc.sv
// Streaming popcount accumulator: sums set bits over a multi-beat vector and emits count + threshold flag.
// Define POPCNT_SAT_EN to saturate the accumulator on overflow; otherwise it wraps modulo 2^CNT_W.
module tnn_popcount_acc #(
  parameter int IN_W  = 14,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic [CNT_W-1:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_fire,
  output logic             out_ovf
);
  localparam int PC_W = $clog2(IN_W + 1);

  typedef enum logic {ACC, OUT} state_t;
  state_t state, state_next;

  logic             accept;
  logic [PC_W-1:0]  beat_pc;
  logic             s1_valid;
  logic [PC_W-1:0]  s1_pc;
  logic             s1_last;
  logic [CNT_W-1:0] s1_thr;
  logic [CNT_W-1:0] acc;
  logic             ovf;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] acc_next;
  logic             ovf_next;
  logic [CNT_W-1:0] res_count;
  logic             res_fire;
  logic             res_ovf;

  assign accept = in_valid && in_ready;

  always_comb begin
    beat_pc = '0;
    for (int i = 0; i < IN_W; i++) begin
      beat_pc = beat_pc + PC_W'(in_data[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pc    <= '0;
      s1_last  <= 1'b0;
      s1_thr   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pc   <= beat_pc;
        s1_last <= in_last;
        if (in_last) begin
          s1_thr <= threshold;
        end
      end
    end
  end

  // One extra bit catches the carry-out that marks overflow.
  always_comb begin
    sum      = {1'b0, acc} + (CNT_W + 1)'(s1_pc);
    ovf_next = ovf | sum[CNT_W];
`ifdef POPCNT_SAT_EN
    acc_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
    acc_next = sum[CNT_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      res_count <= '0;
      res_fire  <= 1'b0;
      res_ovf   <= 1'b0;
    end else if (state == ACC && s1_valid) begin
      if (s1_last) begin
        res_count <= acc_next;
        res_fire  <= (acc_next >= s1_thr);
        res_ovf   <= ovf_next;
        acc       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= acc_next;
        ovf <= ovf_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACC: if (s1_valid && s1_last) state_next = OUT;
      OUT: if (out_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // Input stalls while the closing beat sits in S1 and while a result waits to be taken.
  always_comb begin
    out_valid = (state == OUT);
    in_ready  = !rst && (state == ACC) && !(s1_valid && s1_last);
    out_count = res_count;
    out_fire  = res_fire;
    out_ovf   = res_ovf;
  end

endmodule
